lstm_seq_ctrl: RTL and testbench

- Sequencer that runs one LSTMCell instance over an input sequence of x_t vectors.
- Accepts x_t by valid/ready handshake and drives the cell's xt, ht1 and ct1 inputs, holding them stable for the cell's fixed pipeline latency.
- Captures ht/ct from the cell, feeds them back as recurrent state, and streams each (h_t, c_t) pair out with valid/ready.
- Sits between the input buffer and the LSTMCell datapath.

---
 rtl/lstm_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_lstm_seq_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lstm_seq_ctrl
// Runs one LSTMCell instance over a sequence of x_t vectors. Each step takes
// an x_t over a valid/ready handshake, holds the cell inputs steady for the
// cell's fixed latency, captures ht/ct, feeds them back as recurrent state and
// streams the (h_t, c_t) pair downstream with valid/ready.
//
// Ports
//   CLOCK_50            system clock
//   reset               synchronous active-high reset
//   start/keep_state/seq_len   run request, sampled only while idle
//   x_valid/x_ready/x_data     x_t input stream (S*N bits)
//   cell_xt/cell_ht1/cell_ct1  inputs to the LSTMCell
//   cell_ht/cell_ct            outputs from the LSTMCell
//   h_valid/h_ready/h_data/c_data   (h_t, c_t) output stream
//   busy                high whenever not idle
//   done                one-cycle pulse at sequence end
//   step_idx            index of the current timestep
// -----------------------------------------------------------------------------
module lstm_seq_ctrl #(
    parameter int N        = 8,
    parameter int S        = 8,
    parameter int CELL_LAT = 4,
    parameter int LEN_W    = 8
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic               keep_state,
    input  logic [LEN_W-1:0]   seq_len,
    input  logic               x_valid,
    output logic               x_ready,
    input  logic [S*N-1:0]     x_data,
    output logic [S*N-1:0]     cell_xt,
    output logic [S*N-1:0]     cell_ht1,
    output logic [N-1:0]       cell_ct1,
    input  logic [N-1:0]       cell_ht,
    input  logic [N-1:0]       cell_ct,
    output logic               h_valid,
    input  logic               h_ready,
    output logic [N-1:0]       h_data,
    output logic [N-1:0]       c_data,
    output logic               busy,
    output logic               done,
    output logic [LEN_W-1:0]   step_idx
);

    localparam int CNT_W = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_RUN   = 3'd2,
        ST_CAPT  = 3'd3,
        ST_EMIT  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_step;
    logic [S*N-1:0]     r_xt;
    logic [N-1:0]       r_hist [S];     // r_hist[0] is the newest h
    logic [N-1:0]       r_c;
    logic [N-1:0]       r_h_data;
    logic [N-1:0]       r_c_data;
    logic               r_x_ready;
    logic               r_h_valid;
    logic               r_busy;
    logic               r_done;

    // One extra bit so the end-of-sequence compare cannot wrap.
    logic [LEN_W:0]     w_step_inc;
    logic               w_last;

    assign w_step_inc = {1'b0, r_step} + {{LEN_W{1'b0}}, 1'b1};
    assign w_last     = (w_step_inc == {1'b0, r_len});

    // Recurrent state drives the cell continuously; a capture shows up on
    // the cell inputs the cycle after CAPT.
    generate
        for (genvar gi = 0; gi < S; gi++) begin : g_ht1
            assign cell_ht1[gi*N +: N] = r_hist[gi];
        end
    endgenerate

    assign cell_ct1 = r_c;
    assign cell_xt  = r_xt;
    assign h_data   = r_h_data;
    assign c_data   = r_c_data;
    assign x_ready  = r_x_ready;
    assign h_valid  = r_h_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign step_idx = r_step;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_step    <= '0;
            r_xt      <= '0;
            r_c       <= '0;
            r_h_data  <= '0;
            r_c_data  <= '0;
            r_x_ready <= 1'b0;
            r_h_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            for (int i = 0; i < S; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            // done is only ever raised on the transition into FIN.
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len  <= seq_len;
                        r_step <= '0;
                        r_busy <= 1'b1;
                        if (!keep_state) begin
                            r_c <= '0;
                            for (int i = 0; i < S; i++) begin
                                r_hist[i] <= '0;
                            end
                        end
                        if (seq_len == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_FETCH;
                            r_x_ready <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (x_valid) begin
                        r_xt      <= x_data;
                        r_cnt     <= CNT_W'(CELL_LAT - 1);
                        r_x_ready <= 1'b0;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // CELL_LAT cycles in RUN puts CAPT at handshake + CELL_LAT + 1.
                    if (r_cnt == '0) begin
                        r_state <= ST_CAPT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_CAPT: begin
                    r_h_data <= cell_ht;
                    r_c_data <= cell_ct;
                    r_c      <= cell_ct;
                    for (int i = S - 1; i > 0; i--) begin
                        r_hist[i] <= r_hist[i-1];
                    end
                    r_hist[0] <= cell_ht;
                    r_h_valid <= 1'b1;
                    r_state   <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (h_ready) begin
                        r_h_valid <= 1'b0;
                        r_step    <= w_step_inc[LEN_W-1:0];
                        if (w_last) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_FETCH;
                            r_x_ready <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lstm_seq_ctrl
// Directed bench for lstm_seq_ctrl. A stand-in LSTM cell answers
// ht = xt[7:0], ct = xt[15:8] + ct1. A transaction-level reference tracks what
// the controller must present after every clock edge (accepted x, pending
// result due time, h history, c, step count, done/busy) and is compared
// against the DUT each cycle. Literal checks pin the reference to
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_lstm_seq_ctrl;

    localparam int N        = 8;
    localparam int S        = 8;
    localparam int CELL_LAT = 4;
    localparam int LEN_W    = 8;

    logic               CLOCK_50 = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               keep_state = 1'b0;
    logic [LEN_W-1:0]   seq_len = '0;
    logic               x_valid = 1'b0;
    logic               x_ready;
    logic [S*N-1:0]     x_data = '0;
    logic [S*N-1:0]     cell_xt;
    logic [S*N-1:0]     cell_ht1;
    logic [N-1:0]       cell_ct1;
    logic [N-1:0]       cell_ht;
    logic [N-1:0]       cell_ct;
    logic               h_valid;
    logic               h_ready = 1'b1;
    logic [N-1:0]       h_data;
    logic [N-1:0]       c_data;
    logic               busy;
    logic               done;
    logic [LEN_W-1:0]   step_idx;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int xr_rises = 0;
    int done_rises = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    // Stand-in cell: combinational, so any wobble on its inputs shows up.
    assign cell_ht = cell_xt[7:0];
    assign cell_ct = cell_xt[15:8] + cell_ct1;

    lstm_seq_ctrl #(.N(N), .S(S), .CELL_LAT(CELL_LAT), .LEN_W(LEN_W)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .start      (start),
        .keep_state (keep_state),
        .seq_len    (seq_len),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .x_data     (x_data),
        .cell_xt    (cell_xt),
        .cell_ht1   (cell_ht1),
        .cell_ct1   (cell_ct1),
        .cell_ht    (cell_ht),
        .cell_ct    (cell_ct),
        .h_valid    (h_valid),
        .h_ready    (h_ready),
        .h_data     (h_data),
        .c_data     (c_data),
        .busy       (busy),
        .done       (done),
        .step_idx   (step_idx)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference: what must be visible after each rising edge.
    // ------------------------------------------------------------------
    int             ecount = 0;
    int             m_due = -1;
    bit             m_busy, m_xr, m_hv, m_done;
    logic [7:0]     m_len, m_step, m_c, m_h_out, m_c_out;
    logic [63:0]    m_x;
    logic [7:0]     m_hist [S];

    function automatic logic [63:0] pack_hist();
        logic [63:0] v;
        for (int i = 0; i < S; i++) v[i*8 +: 8] = m_hist[i];
        return v;
    endfunction

    initial begin
        bit prev_xr = 1'b0;
        bit prev_done = 1'b0;
        forever begin
            @(posedge CLOCK_50);
            ecount++;
            if (reset) begin
                {m_busy, m_xr, m_hv, m_done} = '0;
                m_len = 0; m_step = 0; m_c = 0; m_h_out = 0; m_c_out = 0; m_x = 0;
                m_due = -1;
                for (int i = 0; i < S; i++) m_hist[i] = 0;
            end else if (m_due == ecount) begin
                // Result of the accepted x_t is taken from the cell now.
                m_h_out = m_x[7:0];
                m_c_out = m_x[15:8] + m_c;
                for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = m_h_out;
                m_c  = m_c_out;
                m_hv = 1'b1;
                m_due = -1;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_len  = seq_len;
                    m_step = 0;
                    if (!keep_state) begin
                        m_c = 0;
                        for (int i = 0; i < S; i++) m_hist[i] = 0;
                    end
                    if (seq_len == 0) m_done = 1'b1;
                    else              m_xr   = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end else if (m_xr && x_valid) begin
                m_xr  = 1'b0;
                m_x   = x_data;
                m_due = ecount + CELL_LAT + 1;
            end else if (m_hv && h_ready) begin
                m_hv = 1'b0;
                m_step = m_step + 1;
                if (m_step == m_len) m_done = 1'b1;
                else                 m_xr   = 1'b1;
            end
            #1;
            if (chk_en) begin
                check("x_ready",  x_ready,  m_xr);
                check("h_valid",  h_valid,  m_hv);
                check("busy",     busy,     m_busy);
                check("done",     done,     m_done);
                check("step_idx", step_idx, m_step);
                check("cell_xt",  cell_xt,  m_x);
                check("cell_ht1", cell_ht1, pack_hist());
                check("cell_ct1", cell_ct1, m_c);
                check("h_data",   h_data,   m_h_out);
                check("c_data",   c_data,   m_c_out);
            end
            if (x_ready && !prev_xr) xr_rises++;
            if (done && !prev_done) done_rises++;
            prev_xr = x_ready;
            prev_done = done;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic pulse_start(input logic [7:0] len, input bit keep);
        @(negedge CLOCK_50);
        start = 1'b1; seq_len = len; keep_state = keep;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic send_x(input logic [63:0] data);
        bit got = 1'b0;
        @(negedge CLOCK_50);
        x_data = data; x_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge CLOCK_50);
            got = x_ready;
        end
        if (!got) check("x_handshake_timeout", 0, 1);
        @(negedge CLOCK_50);
        x_valid = 1'b0;
    endtask

    // which: 0 = h_valid, 1 = done. Returns rising edges waited.
    task automatic wait_for(input int which, output int edges);
        bit seen = 1'b0;
        edges = 0;
        while (!seen && edges < 300) begin
            @(posedge CLOCK_50); #1;
            edges++;
            seen = (which == 0) ? h_valid : done;
        end
        if (!seen) check(which == 0 ? "h_valid_timeout" : "done_timeout", 0, 1);
    endtask

    initial begin
        int e, xr0, d0;
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, xr0, d0;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_ht1", cell_ht1, 0);

        // Single step: ht=0x11, ct=0x22.
        pulse_start(8'd1, 1'b0);
        send_x(64'h2211);
        wait_for(0, e);
        check("t1_hvalid_latency", e, CELL_LAT + 1);
        check("t1_h_data", h_data, 8'h11);
        check("t1_c_data", c_data, 8'h22);
        wait_for(1, e);
        check("t1_done_latency", e, 1);
        @(negedge CLOCK_50);
        check("t1_ht1", cell_ht1, 64'h11);
        check("t1_ct1", cell_ct1, 8'h22);
        $display("txn: single step done");

        // Three steps, ht = 0xA0 + step.
        @(negedge CLOCK_50);
        xr0 = xr_rises; d0 = done_rises;
        pulse_start(8'd3, 1'b0);
        for (int i = 0; i < 3; i++) send_x(64'h0100 | (64'hA0 + 64'(i)));
        wait_for(1, e);
        repeat (2) @(negedge CLOCK_50);
        check("t2_ht1", cell_ht1, 64'h00A0A1A2);
        check("t2_ct1", cell_ct1, 8'h03);
        check("t2_xready_count", xr_rises - xr0, 3);
        check("t2_done_count", done_rises - d0, 1);
        $display("txn: three-step sequence done");

        // Backpressure for 10 cycles in EMIT.
        h_ready = 1'b0;
        pulse_start(8'd1, 1'b1);
        send_x(64'h045A);
        wait_for(0, e);
        for (int i = 0; i < 10; i++) begin
            @(posedge CLOCK_50); #1;
            check("t3_hold_valid", h_valid, 1);
            check("t3_hold_h", h_data, 8'h5A);
            check("t3_hold_c", c_data, 8'h07);
            check("t3_hold_xr", x_ready, 0);
            check("t3_hold_step", step_idx, 0);
        end
        @(negedge CLOCK_50);
        h_ready = 1'b1;
        wait_for(1, e);
        check("t3_done_latency", e, 1);
        $display("txn: backpressure done");

        // seq_len = 0: straight to done.
        repeat (2) @(negedge CLOCK_50);
        xr0 = xr_rises;
        start = 1'b1; seq_len = 8'd0; keep_state = 1'b1;
        @(posedge CLOCK_50); #1;
        check("t4_done", done, 1);
        @(negedge CLOCK_50);
        start = 1'b0;
        @(posedge CLOCK_50); #1;
        check("t4_done_cleared", done, 0);
        check("t4_busy_cleared", busy, 0);
        check("t4_no_xready", xr_rises - xr0, 0);
        $display("txn: zero-length sequence done");

        // Reset in the middle of RUN abandons the step and clears state.
        pulse_start(8'd2, 1'b1);
        send_x(64'h0133);
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_ht1", cell_ht1, 0);
        check("t5_ct1", cell_ct1, 0);
        check("t5_xt", cell_xt, 0);
        pulse_start(8'd1, 1'b1);
        check("t5_keep_ct1", cell_ct1, 0);
        send_x(64'h0205);
        wait_for(0, e);
        check("t5_h_data", h_data, 8'h05);
        check("t5_c_data", c_data, 8'h02);
        wait_for(1, e);
        $display("txn: reset mid-run done");

        // Start while busy is ignored; keep_state carries c into a new run.
        @(negedge CLOCK_50);
        pulse_start(8'd3, 1'b0);
        send_x(64'h0210);
        pulse_start(8'd1, 1'b0);
        send_x(64'h0211);
        send_x(64'h0212);
        wait_for(1, e);
        check("t6_step_final", step_idx, 3);
        @(negedge CLOCK_50);
        check("t6_ct1", cell_ct1, 8'h06);
        pulse_start(8'd1, 1'b1);
        check("t6_keep_ct1", cell_ct1, 8'h06);
        send_x(64'h0320);
        wait_for(0, e);
        check("t6_c_data", c_data, 8'h09);
        wait_for(1, e);
        @(negedge CLOCK_50);
        check("t6_ht1", cell_ht1, 64'h10111220);
        $display("txn: busy-start and keep_state done");

        repeat (3) @(negedge CLOCK_50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
